fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of `control`. Holds the program counter and issues word reads to instruction memory. Presents each fetched word as the instruction register (`ir`) with a valid/ready handshake to decode. Accepts taken-branch/jump redirects from `control` and discards any in-flight fetch made stale by the redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address of the first instruction fetched after reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request to instruction memory; held high until `imem_ack`.
- `imem_addr`  out  32  byte address of the request; stable while `imem_req` is high.
- `imem_ack`  in  1  memory has data on `imem_rdata` this cycle; completes the request.
- `imem_rdata`  in  32  instruction word, valid only when `imem_ack` is high.
- `ir`  out  32  instruction word to decode.
- `ir_pc`  out  32  byte address `ir` was fetched from.
- `ir_valid`  out  1  `ir`/`ir_pc` hold an undelivered instruction.
- `ir_ready`  in  1  decode accepts `ir` this cycle.
- `redirect`  in  1  branch/jump taken; fetch must resume at `redirect_pc`.
- `redirect_pc`  in  32  target byte address; bits [1:0] ignored and treated as 00.

## Operation
- Internal state: `pc` (32 b), `pend_pc` (32 b), FSM ∈ {IDLE, FETCH, FULL, DRAIN}.
- Reset values: FSM=IDLE, `pc`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `ir`=0, `ir_pc`=0, `ir_valid`=0, `pend_pc`=0.
- IDLE: the next edge always goes to FETCH. IDLE is left only this way.
- FETCH: `imem_req`=1, `imem_addr`=`pc`.
  - On `imem_ack` with no `redirect`: `ir`<=`imem_rdata`, `ir_pc`<=`pc`, `pc`<=`pc`+4, `ir_valid`<=1, go FULL.
- FULL: `imem_req`=0, `ir_valid`=1, and `ir`/`ir_pc` are held.
  - On `ir_ready` with no `redirect`: `ir_valid`<=0, go FETCH. The next address is the already-incremented `pc`.
- DRAIN: `imem_req`=1, `imem_addr` is unchanged from the abandoned request. The request is never withdrawn before its ack.
  - On `imem_ack`: discard `imem_rdata`, `pc`<=`pend_pc`, go FETCH.
- Redirect priority: `redirect` overrides every other event in the same cycle. With target T = {`redirect_pc`[31:2],2'b00}:
  - FETCH, no ack: `pend_pc`<=T, go DRAIN.
  - FETCH, with ack: discard data, `ir_valid` stays 0, `pc`<=T, go FETCH.
  - FULL: `ir_valid`<=0 whatever `ir_ready` is (the instruction is squashed), `pc`<=T, go FETCH.
  - DRAIN: `pend_pc`<=T, so the newest redirect wins. If ack arrives in the same cycle, go FETCH with `pc`<=T.
  - IDLE: `pc`<=T, go FETCH.
- Arithmetic: `pc`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. `pc`[1:0] is always 00.
- `imem_addr` is registered and equals `pc` in FETCH. It does not change during a pending request.

## Timing
- Fetch latency: if `imem_ack` arrives at edge N, `ir_valid` is high from N to N+1.
- Zero-wait memory (ack in the same cycle as req) gives one instruction per 2 cycles. Each extra wait cycle adds 1.
- Handshake: an instruction is transferred at an edge where `ir_valid`&&`ir_ready`. `imem_req` rises for the next address at that same edge.
- Redirect cost:
  - From FULL or FETCH+ack, the first request to T is issued 1 cycle later.
  - From DRAIN, the first request to T is issued 1 cycle after the stale ack.
- `ir_valid` never goes high for a word whose request was outstanding when `redirect` was sampled.
- Reset mid-operation: `rst_n` low immediately forces all reset values, including `imem_req`=0. A pending memory request is abandoned; the memory controller is reset on the same net.

## Test plan
- Reset and release, memory acks in the same cycle as req, `ir_ready`=1 constantly, memory returns word = address:
  - `imem_req`=0 during reset.
  - Fetch addresses 0, 4, 8, 12.
  - `ir`/`ir_pc` = 0/0, 4/4, 8/8, 12/12 with `ir_valid` high every other cycle.
- Memory acks 3 cycles after req: `imem_addr` stays constant for all 3 cycles and `ir_valid` rises the edge after ack.
- `ir_ready`=0 for 5 cycles while `ir_valid`=1: `ir`, `ir_pc` and `ir_valid` are held and `imem_req`=0. Release delivers the word exactly once.
- `redirect`=1, `redirect_pc`=32'h0000_0103 while in FULL at `ir_pc`=8:
  - `ir_valid` drops next cycle.
  - The next `imem_addr` is 32'h100.
  - Address 0xC is never fetched.
- `redirect` to 0x200 two cycles into a 4-cycle-latency request at 0x10, then `redirect` to 0x300 one cycle later:
  - `imem_addr` stays 0x10 until ack and that data never appears on `ir`.
  - The next `imem_addr` is 0x300.
- `RESET_PC`=32'hFFFF_FFFC: the second fetch address is 0. Asserting `rst_n`=0 mid-request clears `imem_req` and `ir_valid` immediately, and fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage feeding decode. Holds the program counter, issues
// word reads to instruction memory with a req/ack handshake, and presents each
// fetched word on ir/ir_pc with a valid/ready handshake. A taken branch or jump
// (redirect) restarts fetch at a new target. A read still in flight when the
// redirect arrives is drained and its data thrown away.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   imem_req/imem_addr  read request and byte address to instruction memory
//   imem_ack/imem_rdata memory completion and returned instruction word
//   ir/ir_pc/ir_valid   instruction, its byte address, and its valid flag
//   ir_ready            decode accepts ir this cycle
//   redirect/redirect_pc  resume fetch at redirect_pc (low two bits ignored)

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] next_pc;
    logic [31:0] next_pend_pc;
    logic [31:0] target;
    logic        load_ir;

    // Masking (rather than slicing) keeps the ignored low bits word-aligned.
    assign target = redirect_pc & 32'hFFFF_FFFC;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and next-datapath logic. A redirect overrides every other
    // event in the same cycle. A request that is still outstanding when the
    // redirect is seen cannot be withdrawn, so it is parked in DRAIN with the
    // target held in pend_pc. The newest redirect overwrites pend_pc.
    always_comb begin
        next_state   = state;
        next_pc      = pc;
        next_pend_pc = pend_pc;
        load_ir      = 1'b0;
        case (state)
            IDLE: begin
                next_state = FETCH;
                if (redirect) begin
                    next_pc = target;
                end
            end
            FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        next_pc = target;
                    end else begin
                        next_pend_pc = target;
                        next_state   = DRAIN;
                    end
                end else if (imem_ack) begin
                    load_ir    = 1'b1;
                    next_pc    = pc + 32'd4;
                    next_state = FULL;
                end
            end
            FULL: begin
                if (redirect) begin
                    next_pc    = target;
                    next_state = FETCH;
                end else if (ir_ready) begin
                    next_state = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    next_pend_pc = target;
                end
                if (imem_ack) begin
                    next_pc    = redirect ? target : pend_pc;
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. imem_addr follows the next pc except while a
    // request is being drained, so the address stays stable until its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            pend_pc   <= 32'h0;
            imem_addr <= RESET_PC;
            ir        <= 32'h0;
            ir_pc     <= 32'h0;
        end else begin
            pc      <= next_pc;
            pend_pc <= next_pend_pc;
            if (next_state != DRAIN) begin
                imem_addr <= next_pc;
            end
            if (load_ir) begin
                ir    <= imem_rdata;
                ir_pc <= pc;
            end
        end
    end

    // Outputs decoded from the registered state. Reset forces IDLE, so both
    // the request and the valid flag drop as soon as rst_n goes low.
    always_comb begin
        imem_req = (state == FETCH) || (state == DRAIN);
        ir_valid = (state == FULL);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Self-checking bench for fetch_unit. Instance a uses the default reset pc and
// a memory model with programmable latency that returns word = address.
// Instance b starts at 32'hFFFF_FFFC behind a zero-wait memory that can be
// stalled. Expected deliveries go into per-instance queues that are popped
// by a monitor whenever decode accepts an instruction.

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        rst_n_b;
    logic        req_b;
    logic [31:0] addr_b;
    logic        ack_b;
    logic [31:0] rdata_b;
    logic [31:0] ir_b;
    logic [31:0] ir_pc_b;
    logic        valid_b;
    logic        ready_b;
    logic        ack_en_b;
    logic        redirect_b;
    logic [31:0] redirect_pc_b;

    int          n_tests = 0;
    int          n_fail = 0;
    int          lat_a = 0;
    int          wait_cnt = 0;
    int          budget;
    bit          saw_c = 1'b0;
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];
    logic [63:0] exp_a;
    logic [63:0] exp_b;

    fetch_unit dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n_b),
        .imem_req   (req_b),
        .imem_addr  (addr_b),
        .imem_ack   (ack_b),
        .imem_rdata (rdata_b),
        .ir         (ir_b),
        .ir_pc      (ir_pc_b),
        .ir_valid   (valid_b),
        .ir_ready   (ready_b),
        .redirect   (redirect_b),
        .redirect_pc(redirect_pc_b)
    );

    always #5 clk = ~clk;

    // Zero-wait memory for instance b, stalled when ack_en_b is low.
    assign ack_b   = req_b & ack_en_b;
    assign rdata_b = addr_b;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: got no event, expected one within the cycle budget", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
        ir_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
    endtask

    task automatic doResetA(input int lat);
        rst_n = 1'b0;
        lat_a = lat;
        applyStimulus(1'b0, 1'b0, 32'h0);
        repeat (2) tick();
        checkOutput("reset imem_req", 32'(imem_req), 32'h0);
        checkOutput("reset ir_valid", 32'(ir_valid), 32'h0);
        checkOutput("reset imem_addr", imem_addr, 32'h0);
        checkOutput("reset ir", ir, 32'h0);
        checkOutput("reset ir_pc", ir_pc, 32'h0);
        rst_n = 1'b1;
    endtask

    // Memory model for instance a: acks after lat_a wait cycles with
    // data equal to the requested address. Also notes any request to 0xC.
    always @(negedge clk) begin
        if (!rst_n) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
        end else begin
            if (imem_ack) begin
                wait_cnt = 0;
            end
            if (imem_req) begin
                if (imem_addr == 32'hC) begin
                    saw_c = 1'b1;
                end
                if (wait_cnt >= lat_a) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr;
                end else begin
                    imem_ack = 1'b0;
                    wait_cnt++;
                end
            end else begin
                imem_ack = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard monitor for instance a.
    always @(negedge clk) begin
        if (rst_n && ir_valid && ir_ready && !redirect) begin
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL a unexpected delivery: got ir_pc %h, expected none", ir_pc);
            end else begin
                exp_a = q_a.pop_front();
                checkOutput("a ir", ir, exp_a[63:32]);
                checkOutput("a ir_pc", ir_pc, exp_a[31:0]);
            end
        end
    end

    // Scoreboard monitor for instance b.
    always @(negedge clk) begin
        if (rst_n_b && valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL b unexpected delivery: got ir_pc %h, expected none", ir_pc_b);
            end else begin
                exp_b = q_b.pop_front();
                checkOutput("b ir", ir_b, exp_b[63:32]);
                checkOutput("b ir_pc", ir_pc_b, exp_b[31:0]);
            end
        end
    end

    initial begin
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        rst_n         = 1'b0;
        rst_n_b       = 1'b0;
        ready_b       = 1'b0;
        ack_en_b      = 1'b1;
        redirect_b    = 1'b0;
        redirect_pc_b = 32'h0;
        applyStimulus(1'b0, 1'b0, 32'h0);

        // Zero-wait memory, decode always ready: one instruction per 2 cycles.
        doResetA(0);
        for (int k = 0; k < 4; k++) begin
            q_a.push_back({32'(k * 4), 32'(k * 4)});
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                checkOutput("t1 imem_req", 32'(imem_req), 32'h1);
                checkOutput("t1 imem_addr", imem_addr, 32'(i * 2));
                checkOutput("t1 ir_valid low", 32'(ir_valid), 32'h0);
            end else begin
                checkOutput("t1 ir_valid high", 32'(ir_valid), 32'h1);
                checkOutput("t1 imem_req low", 32'(imem_req), 32'h0);
            end
        end
        tick();
        ir_ready = 1'b0;
        checkOutput("t1 all delivered", 32'(q_a.size()), 32'h0);

        // Three wait cycles, then decode stalls for five cycles.
        doResetA(3);
        q_a.push_back({32'h0, 32'h0});
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t2 imem_req held", 32'(imem_req), 32'h1);
            checkOutput("t2 imem_addr stable", imem_addr, 32'h0);
            checkOutput("t2 ir_valid low", 32'(ir_valid), 32'h0);
        end
        tick();
        checkOutput("t2 ir_valid after ack", 32'(ir_valid), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t3 ir_valid held", 32'(ir_valid), 32'h1);
            checkOutput("t3 imem_req low", 32'(imem_req), 32'h0);
            checkOutput("t3 ir held", ir, 32'h0);
            checkOutput("t3 ir_pc held", ir_pc, 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("t3 ir_valid after accept", 32'(ir_valid), 32'h0);
        checkOutput("t3 next imem_req", 32'(imem_req), 32'h1);
        checkOutput("t3 next imem_addr", imem_addr, 32'h4);
        checkOutput("t3 delivered once", 32'(q_a.size()), 32'h0);

        // Redirect while holding the instruction from address 8.
        doResetA(0);
        saw_c = 1'b0;
        q_a.push_back({32'h0, 32'h0});
        q_a.push_back({32'h4, 32'h4});
        q_a.push_back({32'h100, 32'h100});
        applyStimulus(1'b1, 1'b0, 32'h0);
        budget = 0;
        do begin
            tick();
            budget++;
        end while (!(ir_valid && ir_pc == 32'h8) && budget < 20);
        if (!(ir_valid && ir_pc == 32'h8)) begin
            timeoutFail("t4 reach ir_pc 8");
        end
        checkOutput("t4 ir at 8", ir, 32'h8);
        applyStimulus(1'b1, 1'b1, 32'h0000_0103);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("t4 ir_valid squashed", 32'(ir_valid), 32'h0);
        checkOutput("t4 redirect imem_req", 32'(imem_req), 32'h1);
        checkOutput("t4 redirect imem_addr", imem_addr, 32'h100);
        budget = 0;
        while (q_a.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        if (q_a.size() != 0) begin
            timeoutFail("t4 deliver 0x100");
        end
        ir_ready = 1'b0;
        checkOutput("t4 0xC never fetched", 32'(saw_c), 32'h0);

        // Two redirects during a four-wait-cycle request at 0x10.
        doResetA(4);
        for (int k = 0; k < 4; k++) begin
            q_a.push_back({32'(k * 4), 32'(k * 4)});
        end
        applyStimulus(1'b1, 1'b0, 32'h0);
        budget = 0;
        do begin
            tick();
            budget++;
        end while (!(imem_req && imem_addr == 32'h10) && budget < 80);
        if (!(imem_req && imem_addr == 32'h10)) begin
            timeoutFail("t5 reach request 0x10");
        end
        for (int c = 0; c < 5; c++) begin
            checkOutput("t5 imem_addr held 0x10", imem_addr, 32'h10);
            checkOutput("t5 imem_req held", 32'(imem_req), 32'h1);
            checkOutput("t5 ir_valid low", 32'(ir_valid), 32'h0);
            if (c == 2) begin
                applyStimulus(1'b1, 1'b1, 32'h200);
            end else if (c == 3) begin
                applyStimulus(1'b1, 1'b1, 32'h300);
            end else begin
                applyStimulus(1'b1, 1'b0, 32'h0);
            end
            tick();
        end
        checkOutput("t5 imem_req to 0x300", 32'(imem_req), 32'h1);
        checkOutput("t5 imem_addr 0x300", imem_addr, 32'h300);
        q_a.push_back({32'h300, 32'h300});
        budget = 0;
        while (q_a.size() != 0 && budget < 20) begin
            tick();
            budget++;
        end
        if (q_a.size() != 0) begin
            timeoutFail("t5 deliver 0x300");
        end
        ir_ready = 1'b0;

        // Reset pc at the top of the address space, then reset mid-request.
        ready_b  = 1'b1;
        ack_en_b = 1'b1;
        q_b.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC});
        q_b.push_back({32'h0, 32'h0});
        tick();
        rst_n_b = 1'b1;
        tick();
        checkOutput("t6 first imem_req", 32'(req_b), 32'h1);
        checkOutput("t6 first imem_addr", addr_b, 32'hFFFF_FFFC);
        tick();
        checkOutput("t6 ir_valid", 32'(valid_b), 32'h1);
        tick();
        checkOutput("t6 wrapped imem_addr", addr_b, 32'h0);
        tick();
        ack_en_b = 1'b0;
        tick();
        checkOutput("t6 pending imem_addr", addr_b, 32'h4);
        tick();
        checkOutput("t6 pending imem_req", 32'(req_b), 32'h1);
        rst_n_b = 1'b0;
        #1;
        checkOutput("t6 reset imem_req", 32'(req_b), 32'h0);
        checkOutput("t6 reset ir_valid", 32'(valid_b), 32'h0);
        checkOutput("t6 reset imem_addr", addr_b, 32'hFFFF_FFFC);
        checkOutput("t6 delivered before reset", 32'(q_b.size()), 32'h0);
        tick();
        q_b.push_back({32'hFFFF_FFFC, 32'hFFFF_FFFC});
        ack_en_b = 1'b1;
        rst_n_b  = 1'b1;
        tick();
        checkOutput("t6 restart imem_req", 32'(req_b), 32'h1);
        checkOutput("t6 restart imem_addr", addr_b, 32'hFFFF_FFFC);
        budget = 0;
        while (q_b.size() != 0 && budget < 10) begin
            tick();
            budget++;
        end
        if (q_b.size() != 0) begin
            timeoutFail("t6 deliver after restart");
        end
        ready_b = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
